// File: rtl/plane_pwm_controller.sv
// Double-buffered multi-channel PWM plane controller with an 8-bit host command/data bus.
// Build option: define PWM_PHASE_STAGGER_EN to right-align odd channels.
module plane_pwm_controller #(
  parameter int CHANNELS = 64,
  parameter int D_WIDTH  = 8,
  parameter int C_WIDTH  = 5,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [D_WIDTH-1:0]  dataIn,
  input  logic                dataEn,
  input  logic                rs,
  output logic [CHANNELS-1:0] pwmOut,
  output logic                commitPending
);

  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_WIDTH-1:0] CNT_MAX   = C_WIDTH'((1 << C_WIDTH) - 2);
  localparam logic [C_WIDTH-1:0] DUTY_FULL = '1;
  localparam logic [PW-1:0]      PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [AW-1:0]      LAST_CH   = AW'(CHANNELS - 1);

  logic                r_en_q;
  logic [AW-1:0]       r_wptr;
  logic                r_out_en;
  logic                r_auto;
  logic                r_pending;
  logic [PW-1:0]       r_pre;
  logic [C_WIDTH-1:0]  r_cnt;
  logic [C_WIDTH-1:0]  r_shadow [CHANNELS];
  logic [C_WIDTH-1:0]  r_active [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;

  logic                w_write;
  logic                w_cmd;
  logic                w_data;
  logic [1:0]          w_opcode;
  logic [5:0]          w_operand;
  logic                w_addr_ok;
  logic                w_set_addr;
  logic                w_set_ctrl;
  logic                w_commit;
  logic                w_auto_commit;
  logic                w_pre_wrap;
  logic                w_boundary;
  logic                w_swap;
  logic [CHANNELS-1:0] w_on;

  // dataEn is a level strobe: exactly one write is taken on each rising edge,
  // with dataIn/rs sampled in that same cycle.
  assign w_write       = dataEn & ~r_en_q;
  assign w_cmd         = w_write & rs;
  assign w_data        = w_write & ~rs;
  assign w_opcode      = dataIn[7:6];
  assign w_operand     = dataIn[5:0];
  assign w_addr_ok     = int'(w_operand) < CHANNELS;
  assign w_set_addr    = w_cmd && (w_opcode == 2'b00) && w_addr_ok;
  assign w_set_ctrl    = w_cmd && (w_opcode == 2'b01);
  assign w_commit      = w_cmd && (w_opcode == 2'b10);
  assign w_auto_commit = w_data && r_auto && (r_wptr == LAST_CH);

  assign w_pre_wrap = (r_pre == PRE_MAX);
  assign w_boundary = w_pre_wrap && (r_cnt == CNT_MAX);
  assign w_swap     = w_boundary && r_pending;

  always_comb begin
    w_on = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_on[i] = (r_active[i] > r_cnt);
`ifdef PWM_PHASE_STAGGER_EN
      if ((i % 2) == 1) w_on[i] = (r_cnt >= (DUTY_FULL - r_active[i]));
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_q    <= 1'b0;
      r_wptr    <= '0;
      r_out_en  <= 1'b1;
      r_auto    <= 1'b0;
      r_pending <= 1'b0;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_pwm     <= '0;
    end else begin
      r_en_q <= dataEn;
      if (w_set_addr) begin
        r_wptr <= w_operand[AW-1:0];
      end else if (w_data) begin
        r_wptr <= (r_wptr == LAST_CH) ? '0 : r_wptr + 1'b1;
      end
      if (w_set_ctrl) begin
        r_out_en <= dataIn[0];
        r_auto   <= dataIn[1];
      end
      // A new request arriving on a swap boundary survives to the next boundary.
      r_pending <= w_commit | w_auto_commit | (r_pending & ~w_boundary);
      r_pre     <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap) r_cnt <= w_boundary ? '0 : r_cnt + 1'b1;
      r_pwm <= r_out_en ? w_on : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_data) r_shadow[r_wptr] <= dataIn[C_WIDTH-1:0];
      if (w_swap) begin
        for (int i = 0; i < CHANNELS; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  assign pwmOut        = r_pwm;
  assign commitPending = r_pending;

endmodule

// File: tb/tb_plane_pwm_controller.sv
// Directed bench for plane_pwm_controller (CHANNELS=64, C_WIDTH=5, PRESCALE=1).
// Expected results are queued when each step is driven and popped at the observation point.
module tb_plane_pwm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dataIn;
  logic        dataEn;
  logic        rs;
  logic [63:0] pwmOut;
  logic        commitPending;

  logic [31:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  plane_pwm_controller #(
    .CHANNELS(64), .D_WIDTH(8), .C_WIDTH(5), .PRESCALE(1)
  ) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataEn(dataEn), .rs(rs),
    .pwmOut(pwmOut), .commitPending(commitPending)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
    end
  endtask

  // One bus write; pend is commitPending seen in the first cycle after the write edge.
  task automatic wr(input logic is_cmd, input logic [7:0] d, input int hold,
                    output logic pend);
    @(negedge clk);
    rs = is_cmd; dataIn = d; dataEn = 1'b1;
    @(negedge clk);
    pend = commitPending;
    repeat (hold - 1) @(negedge clk);
    dataEn = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_clear(input string tag);
    for (int i = 0; i < 100 && commitPending; i++) @(negedge clk);
    exp_q.push_back(32'd0);
    check(tag, {31'd0, commitPending});
  endtask

  // Counts cycles channel ch is high, and cycles any other channel is high.
  task automatic measure(input int ch, input int n, output int highs, output int others);
    logic [63:0] mask;
    highs = 0; others = 0;
    repeat (n) begin
      @(negedge clk);
      mask = pwmOut;
      highs += int'(mask[ch]);
      mask[ch] = 1'b0;
      if (mask != 64'd0) others++;
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwmOut != 64'd0 || commitPending) bad++;
    end
    exp_q.push_back(32'd0);
    check(tag, bad);
  endtask

  initial begin
    logic        p;
    int          h, o, run;
    logic [30:0] m0, m1;
    logic        prev;

    reset = 1'b0; dataEn = 1'b0; rs = 1'b0; dataIn = 8'h00;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'd0); check("reset_pwm", pwmOut[31:0] | pwmOut[63:32]);
    exp_q.push_back(32'd0); check("reset_pend", {31'd0, commitPending});
    reset = 1'b1;
    idle_check("idle_2_periods", 62);

    // ch0 = 15, commit, then 15 of 31 cycles high
    wr(1'b1, 8'h00, 1, p);
    wr(1'b0, 8'h0F, 1, p);
    exp_q.push_back(32'd1);
    wr(1'b1, 8'h80, 1, p);
    check("commit_pending", {31'd0, p});
    wait_clear("commit_clear");
    exp_q.push_back(32'd15); exp_q.push_back(32'd0);
    measure(0, 31, h, o);
    check("ch0_duty15", h);
    check("ch0_others_low", o);

    // reserved opcode does nothing; held strobe gives one write; repeated commits
    exp_q.push_back(32'd0);
    wr(1'b1, 8'hC0, 1, p);
    check("reserved_no_pend", {31'd0, p});
    wr(1'b1, 8'h02, 1, p);
    wr(1'b0, 8'h0A, 4, p);
    wr(1'b0, 8'h05, 1, p);
    wr(1'b1, 8'h80, 1, p);
    wr(1'b1, 8'h80, 1, p);
    wait_clear("hold_commit_clear");
    exp_q.push_back(32'd10); measure(2, 31, h, o); check("ch2_held_write", h);
    exp_q.push_back(32'd5);  measure(3, 31, h, o); check("ch3_next_addr", h);
    exp_q.push_back(32'd0);  measure(4, 31, h, o); check("ch4_untouched", h);

    // COMMIT landing exactly on the boundary cycle (cnt=30)
    prev = pwmOut[0];
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwmOut[0] && !prev) break;
      prev = pwmOut[0];
    end
    repeat (29) @(negedge clk);
    rs = 1'b1; dataIn = 8'h80; dataEn = 1'b1;
    run = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      dataEn = 1'b0;
      if (commitPending) run++;
      else break;
    end
    exp_q.push_back(32'd31);
    check("boundary_commit_len", run);

    // autoCommit with outputs disabled (0x42), then enabled (0x43)
    wr(1'b1, 8'h00, 1, p);
    wr(1'b1, 8'h42, 1, p);
    for (int i = 0; i < 63; i++) wr(1'b0, 8'h1F, 1, p);
    exp_q.push_back(32'd0); check("auto_pend_byte63", {31'd0, p});
    wr(1'b0, 8'h1F, 1, p);
    exp_q.push_back(32'd1); check("auto_pend_byte64", {31'd0, p});
    wait_clear("auto_clear");
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    measure(0, 31, h, o);
    check("outen0_ch0", h);
    check("outen0_others", o);
    wr(1'b1, 8'h43, 1, p);
    exp_q.push_back(32'd31); exp_q.push_back(32'd31);
    measure(63, 31, h, o);
    check("full_ch63", h);
    check("full_others", o);

    // alignment: ch0 = ch1 = 4
    wr(1'b1, 8'h41, 1, p);
    wr(1'b1, 8'h00, 1, p);
    wr(1'b0, 8'h04, 1, p);
    wr(1'b0, 8'h04, 1, p);
    wr(1'b1, 8'h80, 1, p);
    wait_clear("align_clear");
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      m0[k] = pwmOut[0];
      m1[k] = pwmOut[1];
    end
    exp_q.push_back(32'h0000_000F);
`ifdef PWM_PHASE_STAGGER_EN
    exp_q.push_back(32'h7800_0000);
`else
    exp_q.push_back(32'h0000_000F);
`endif
    check("ch0_phase", {1'b0, m0});
    check("ch1_phase", {1'b0, m1});

    // reset mid-frame with a commit pending
    exp_q.push_back(32'd1);
    wr(1'b1, 8'h80, 1, p);
    check("pend_before_reset", {31'd0, p});
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(32'd0); check("midreset_pwm", pwmOut[31:0] | pwmOut[63:32]);
    exp_q.push_back(32'd0); check("midreset_pend", {31'd0, commitPending});
    @(negedge clk);
    reset = 1'b1;
    idle_check("post_reset_idle", 40);
    wr(1'b1, 8'h80, 1, p);
    wait_clear("post_reset_clear");
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    measure(0, 31, h, o);
    check("post_reset_ch0", h);
    check("post_reset_others", o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
